// File: rtl/pixel_stream_processor_if.sv
// Pixel beat stream between the source, the point-operation pipeline and the image writer.
interface pixel_stream_processor_if #(
    parameter int PPC = 2,
    parameter int DW  = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [PPC*3*DW-1:0]   in_data;
    logic                  out_valid;
    logic [PPC*3*DW-1:0]   out_data;

    modport slave  (input  in_valid, in_data, output in_ready, out_valid, out_data);
    modport master (output in_valid, in_data, input  in_ready, out_valid, out_data);
endinterface

// File: rtl/pixel_stream_processor.sv
// Frame-sequenced RGB point-operation pipeline (pass/brightness/invert-gray/threshold),
// PPC lanes per beat, fixed two-stage latency, with VSYNC/HSYNC framing and done pulse.
//
// state      | meaning
// -----------+--------------------------------------------------
// ST_IDLE    | waiting for start, config latched on accepted start
// ST_VSYNC   | startup blanking, STARTUP_DELAY cycles
// ST_HSYNC   | line blanking, HSYNC_DELAY cycles
// ST_DATA    | accepting beats of the current line
// ST_DRAIN   | last beat taken, waiting for the pipe to empty
module pixel_stream_processor #(
    parameter int WIDTH         = 768,
    parameter int HEIGHT        = 512,
    parameter int PPC           = 2,
    parameter int DW            = 8,
    parameter int STARTUP_DELAY = 100,
    parameter int HSYNC_DELAY   = 160
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    input  logic                     start,
    input  logic [2:0]               mode,
    input  logic [DW-1:0]            bright_val,
    input  logic [DW-1:0]            thresh_val,
    pixel_stream_processor_if.slave  px,
    output logic                     VSYNC,
    output logic                     HSYNC,
    output logic                     busy,
    output logic                     ctrl_done
);
    localparam int PW    = 3 * DW;
    localparam int COLS  = WIDTH / PPC;
    localparam int CW    = $clog2(COLS) + 1;
    localparam int RW    = $clog2(HEIGHT) + 1;
    localparam int TMAX  = (STARTUP_DELAY > HSYNC_DELAY) ? STARTUP_DELAY : HSYNC_DELAY;
    localparam int TW    = $clog2(TMAX) + 1;

    typedef enum logic [2:0] {ST_IDLE, ST_VSYNC, ST_HSYNC, ST_DATA, ST_DRAIN} state_t;

    state_t           state, state_nx;
    logic [TW-1:0]    tmr, tmr_nx;
    logic [CW-1:0]    col, col_nx;
    logic [RW-1:0]    row, row_nx;
    logic             cfg_load, accept, v1;
    logic [2:0]       mode_q;
    logic [DW-1:0]    bright_q, thresh_q;
    logic [PPC*PW-1:0] res;

    // Flops release on a synchronised edge but still clear immediately on HRESET.
    logic [1:0] rst_sync;
    logic       rst_b;
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) rst_sync <= 2'b00;
        else         rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_b = rst_sync[1];

    assign accept      = px.in_valid && px.in_ready;
    assign px.in_ready = (state == ST_DATA);
    assign VSYNC       = (state == ST_VSYNC);
    assign busy        = (state != ST_IDLE);
    assign HSYNC       = px.out_valid;

    always_ff @(posedge HCLK or negedge rst_b) begin
        if (!rst_b) begin
            state    <= ST_IDLE;
            tmr      <= '0;
            col      <= '0;
            row      <= '0;
            mode_q   <= '0;
            bright_q <= '0;
            thresh_q <= '0;
        end else begin
            state <= state_nx;
            tmr   <= tmr_nx;
            col   <= col_nx;
            row   <= row_nx;
            if (cfg_load) begin
                mode_q   <= mode;
                bright_q <= bright_val;
                thresh_q <= thresh_val;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        tmr_nx    = tmr;
        col_nx    = col;
        row_nx    = row;
        cfg_load  = 1'b0;
        ctrl_done = 1'b0;
        case (state)
            ST_IDLE: if (start) begin
                state_nx = ST_VSYNC;
                tmr_nx   = TW'(STARTUP_DELAY - 1);
                col_nx   = '0;
                row_nx   = '0;
                cfg_load = 1'b1;
            end
            ST_VSYNC: if (tmr == '0) begin
                state_nx = ST_HSYNC;
                tmr_nx   = TW'(HSYNC_DELAY - 1);
            end else begin
                tmr_nx = tmr - TW'(1);
            end
            ST_HSYNC: if (tmr == '0) state_nx = ST_DATA;
                      else           tmr_nx   = tmr - TW'(1);
            ST_DATA: if (accept) begin
                if (col == CW'(COLS - 1)) begin
                    col_nx = '0;
                    if (row == RW'(HEIGHT - 1)) begin
                        state_nx = ST_DRAIN;
                    end else begin
                        row_nx   = row + RW'(1);
                        state_nx = ST_HSYNC;
                        tmr_nx   = TW'(HSYNC_DELAY - 1);
                    end
                end else begin
                    col_nx = col + CW'(1);
                end
            end
            ST_DRAIN: if (!v1 && !px.out_valid) begin
                ctrl_done = 1'b1;
                state_nx  = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Stage 1 keeps one spare bit per channel so stage 2 can see add overflow / sub underflow.
    for (genvar k = 0; k < PPC; k++) begin : g_lane
        logic [DW+1:0]       sum_d, sum_q;
        logic [2:0][DW:0]    ch_d, ch_q;
        logic [DW-1:0]       gray;
        logic [PW-1:0]       px_o;

        always_comb begin
            sum_d = '0;
            ch_d  = '0;
            for (int c = 0; c < 3; c++) begin
                sum_d = sum_d + {2'b00, px.in_data[PW*k + DW*c +: DW]};
                case (mode_q)
                    3'd1:    ch_d[c] = {1'b0, px.in_data[PW*k + DW*c +: DW]} + {1'b0, bright_q};
                    3'd2:    ch_d[c] = {1'b0, px.in_data[PW*k + DW*c +: DW]} - {1'b0, bright_q};
                    default: ch_d[c] = {1'b0, px.in_data[PW*k + DW*c +: DW]};
                endcase
            end
        end

        always_ff @(posedge HCLK or negedge rst_b) begin
            if (!rst_b) begin
                sum_q <= '0;
                ch_q  <= '0;
            end else begin
                sum_q <= sum_d;
                ch_q  <= ch_d;
            end
        end

        always_comb begin
            gray = DW'(sum_q / (DW+2)'(3));
            px_o = '0;
            for (int c = 0; c < 3; c++) begin
                case (mode_q)
                    3'd1:    px_o[DW*c +: DW] = ch_q[c][DW] ? {DW{1'b1}} : ch_q[c][DW-1:0];
                    3'd2:    px_o[DW*c +: DW] = ch_q[c][DW] ? {DW{1'b0}} : ch_q[c][DW-1:0];
                    3'd3:    px_o[DW*c +: DW] = ~gray;
                    3'd4:    px_o[DW*c +: DW] = (gray > thresh_q) ? {DW{1'b1}} : {DW{1'b0}};
                    default: px_o[DW*c +: DW] = ch_q[c][DW-1:0];
                endcase
            end
        end

        assign res[PW*k +: PW] = px_o;
    end

    always_ff @(posedge HCLK or negedge rst_b) begin
        if (!rst_b) begin
            v1          <= 1'b0;
            px.out_valid <= 1'b0;
            px.out_data  <= '0;
        end else begin
            v1           <= accept;
            px.out_valid <= v1;
            px.out_data  <= v1 ? res : '0;
        end
    end
endmodule
